// File: rtl/base_dbus_mux.sv
// Data-bus decoder between the SERV Wishbone data port and four slaves.
// Memory and timer are acked here; collector and FIFO supply their own ack.
module base_dbus_mux #(
  parameter int sim = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_dbus_adr,
  input  logic [31:0] i_wb_dbus_dat,
  input  logic [3:0]  i_wb_dbus_sel,
  input  logic        i_wb_dbus_we,
  input  logic        i_wb_dbus_cyc,
  output logic [31:0] o_wb_dbus_rdt,
  output logic        o_wb_dbus_ack,
  output logic [31:0] o_wb_dmem_adr,
  output logic [31:0] o_wb_dmem_dat,
  output logic [3:0]  o_wb_dmem_sel,
  output logic        o_wb_dmem_we,
  output logic        o_wb_dmem_cyc,
  input  logic [31:0] i_wb_dmem_rdt,
  output logic [31:0] o_wb_coll_adr,
  output logic [31:0] o_wb_coll_dat,
  output logic        o_wb_coll_we,
  output logic        o_wb_coll_stb,
  input  logic [31:0] i_wb_coll_rdt,
  input  logic        i_wb_coll_ack,
  output logic [31:0] o_wb_timer_dat,
  output logic        o_wb_timer_we,
  output logic        o_wb_timer_cyc,
  input  logic [31:0] i_wb_timer_rdt,
  output logic [8:0]  o_wb_fifo_dat,
  output logic        o_wb_fifo_we,
  output logic        o_wb_fifo_stb,
  input  logic        i_wb_fifo_ack
);

  logic is_dmem;
  logic is_coll;
  logic is_timer;
  logic is_fifo;
  logic ack_r;

  assign is_dmem  = i_wb_dbus_adr[31:30] == 2'b00;
  assign is_coll  = i_wb_dbus_adr[31:30] == 2'b01;
  assign is_timer = i_wb_dbus_adr[31:30] == 2'b10;
  assign is_fifo  = i_wb_dbus_adr[31:30] == 2'b11;

  assign o_wb_dmem_adr  = i_wb_dbus_adr;
  assign o_wb_dmem_dat  = i_wb_dbus_dat;
  assign o_wb_dmem_sel  = i_wb_dbus_sel;
  assign o_wb_dmem_we   = i_wb_dbus_we;
  assign o_wb_dmem_cyc  = i_wb_dbus_cyc & is_dmem;

  assign o_wb_coll_adr  = i_wb_dbus_adr;
  assign o_wb_coll_dat  = i_wb_dbus_dat;
  assign o_wb_coll_we   = i_wb_dbus_we;
  assign o_wb_coll_stb  = i_wb_dbus_cyc & is_coll;

  assign o_wb_timer_dat = i_wb_dbus_dat;
  assign o_wb_timer_we  = i_wb_dbus_we;
  assign o_wb_timer_cyc = i_wb_dbus_cyc & is_timer;

  assign o_wb_fifo_dat  = i_wb_dbus_dat[8:0];
  assign o_wb_fifo_we   = i_wb_dbus_we;
  assign o_wb_fifo_stb  = i_wb_dbus_cyc & is_fifo;

  // ~ack_r makes the internal ack a single pulse while cyc is still high
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= i_wb_dbus_cyc & ~ack_r & (is_dmem | is_timer);
    end
  end

  assign o_wb_dbus_ack = ack_r
                       | (is_coll & i_wb_coll_ack)
                       | (is_fifo & i_wb_fifo_ack);

  always_comb begin
    o_wb_dbus_rdt = 32'h0;
    unique case (1'b1)
      is_dmem:  o_wb_dbus_rdt = i_wb_dmem_rdt;
      is_coll:  o_wb_dbus_rdt = i_wb_coll_rdt;
      is_timer: o_wb_dbus_rdt = i_wb_timer_rdt;
      is_fifo:  o_wb_dbus_rdt = 32'h0;
      default:  o_wb_dbus_rdt = 32'h0;
    endcase
  end

  generate
    if (sim != 0) begin : g_sim
      // Halt/print hooks fire on the acked FIFO-region write
      always @(posedge i_clk) begin
        if (o_wb_fifo_stb & i_wb_dbus_we & o_wb_dbus_ack) begin
          if (i_wb_dbus_adr[29:28] == 2'b11)
            $finish;
          else if (i_wb_dbus_adr[29:28] == 2'b10)
            $write("%c", i_wb_dbus_dat[7:0]);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_base_dbus_mux.sv
// Scoreboard bench for base_dbus_mux: randomized and directed accesses.
// Driver pushes expected read data and ack cycle; monitor pops on ack.
module tb_base_dbus_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic [31:0] rdt;
  logic        ack;
  logic [31:0] dmem_adr, dmem_dat;
  logic [3:0]  dmem_sel;
  logic        dmem_we, dmem_cyc;
  logic [31:0] dmem_rdt = '0;
  logic [31:0] coll_adr, coll_dat;
  logic        coll_we, coll_stb;
  logic [31:0] coll_rdt = '0;
  logic        coll_ack = 1'b0;
  logic [31:0] timer_dat;
  logic        timer_we, timer_cyc;
  logic [31:0] timer_rdt = '0;
  logic [8:0]  fifo_dat;
  logic        fifo_we, fifo_stb;
  logic        fifo_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycles = 0;

  typedef struct {
    logic [31:0] rdt;
    int          at;
  } exp_t;
  exp_t q[$];

  base_dbus_mux #(.sim(0)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_wb_dbus_adr(adr), .i_wb_dbus_dat(dat),
    .i_wb_dbus_sel(sel), .i_wb_dbus_we(we),
    .i_wb_dbus_cyc(cyc),
    .o_wb_dbus_rdt(rdt), .o_wb_dbus_ack(ack),
    .o_wb_dmem_adr(dmem_adr), .o_wb_dmem_dat(dmem_dat),
    .o_wb_dmem_sel(dmem_sel), .o_wb_dmem_we(dmem_we),
    .o_wb_dmem_cyc(dmem_cyc), .i_wb_dmem_rdt(dmem_rdt),
    .o_wb_coll_adr(coll_adr), .o_wb_coll_dat(coll_dat),
    .o_wb_coll_we(coll_we), .o_wb_coll_stb(coll_stb),
    .i_wb_coll_rdt(coll_rdt), .i_wb_coll_ack(coll_ack),
    .o_wb_timer_dat(timer_dat), .o_wb_timer_we(timer_we),
    .o_wb_timer_cyc(timer_cyc), .i_wb_timer_rdt(timer_rdt),
    .o_wb_fifo_dat(fifo_dat), .o_wb_fifo_we(fifo_we),
    .o_wb_fifo_stb(fifo_stb), .i_wb_fifo_ack(fifo_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycles <= cycles + 1;

  // Reference: the slave index is the address divided by 1 GiB
  function automatic int slave_of(input logic [31:0] a);
    return int'(a / 32'h4000_0000);
  endfunction

  function automatic logic [31:0] ref_rdt(input logic [31:0] a);
    case (slave_of(a))
      0: return dmem_rdt;
      1: return coll_rdt;
      2: return timer_rdt;
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: routing every cycle, and scoreboard pop on ack
  always @(negedge clk) begin
    logic [3:0] exp_req;
    logic [3:0] got_req;
    exp_t e;
    exp_req = '0;
    if (cyc) exp_req[slave_of(adr)] = 1'b1;
    got_req = {fifo_stb, timer_cyc, coll_stb, dmem_cyc};
    checks++;
    if (got_req !== exp_req) begin
      errors++;
      $display("FAIL req: got %b want %b adr %h",
               got_req, exp_req, adr);
    end
    checks++;
    if (dmem_adr !== adr || dmem_dat !== dat ||
        dmem_sel !== sel || dmem_we !== we ||
        coll_adr !== adr || coll_dat !== dat ||
        coll_we !== we || timer_dat !== dat ||
        timer_we !== we || fifo_we !== we ||
        fifo_dat !== 9'(dat % 512)) begin
      errors++;
      $display("FAIL pass: fifo_dat %h want %h dmem_adr %h want %h",
               fifo_dat, 9'(dat % 512), dmem_adr, adr);
    end
    if (ack === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_ack: got ack at cycle %0d want none",
                 cycles);
      end else begin
        e = q.pop_front();
        if (rdt !== e.rdt || cycles != e.at) begin
          errors++;
          $display("FAIL ack: rdt %h cyc %0d want rdt %h cyc %0d",
                   rdt, cycles, e.rdt, e.at);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 with cyc low
  task automatic txn(input logic [31:0] a, input logic [31:0] d,
                     input logic w, input logic [3:0] s,
                     input int dly);
    int  r;
    bit  ext;
    int  lat;
    exp_t e;
    r   = slave_of(a);
    ext = (r == 1) || (r == 3);
    lat = ext ? dly : 1;
    adr = a; dat = d; we = w; sel = s; cyc = 1'b1;
    coll_ack = 1'b0; fifo_ack = 1'b0;
    e.rdt = ref_rdt(a);
    e.at  = cycles + lat;
    q.push_back(e);
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      if (!ext) begin
        coll_ack = 1'($urandom_range(0, 1));
        fifo_ack = 1'($urandom_range(0, 1));
      end else if (r == 1) begin
        fifo_ack = 1'($urandom_range(0, 1));
        coll_ack = (i == lat);
      end else begin
        coll_ack = 1'($urandom_range(0, 1));
        fifo_ack = (i == lat);
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; coll_ack = 1'b0; fifo_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    exp_t e;
    logic [31:0] a;
    cyc = 1'b1; adr = 32'h0; dmem_rdt = 32'hCAFE_0001;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ack !== 1'b0) begin
        errors++;
        $display("FAIL rst_ack: got %b want 0", ack);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    e.rdt = 32'hCAFE_0001; e.at = cycles + 1;
    q.push_back(e);
    @(posedge clk); #6;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: got ack %b want 0", ack);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; cyc = 1'b0;
    idle(1);

    dmem_rdt = 32'hDEAD_BEEF;
    timer_rdt = 32'h5555_AAAA;
    coll_rdt = 32'h0BAD_F00D;
    txn(32'h0000_0010, 32'h0, 1'b0, 4'hF, 1);
    txn(32'h8000_0000, 32'h1234, 1'b1, 4'hF, 1);
    txn(32'h8000_0004, 32'h0, 1'b0, 4'hF, 1);
    idle(1);
    txn(32'h4000_0008, 32'h0, 1'b0, 4'hF, 3);
    txn(32'hC000_0000, 32'h1A5, 1'b1, 4'h1, 2);
    txn(32'hC000_0004, 32'h0FF, 1'b1, 4'h1, 8);
    txn(32'h0000_0020, 32'h0, 1'b0, 4'hF, 1);
    txn(32'h8000_0008, 32'h77, 1'b1, 4'hF, 1);

    for (int n = 0; n < 300; n++) begin
      dmem_rdt  = $urandom;
      coll_rdt  = $urandom;
      timer_rdt = $urandom;
      a = $urandom;
      txn(a, $urandom, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), $urandom_range(1, 5));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(4);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_ack: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
